// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: sequences each instruction through fetch, decode,
// execute, memory and writeback. Drives the datapath controls, a req/ack
// memory handshake with an optional timeout, and counts retired instructions.
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT = 0,
  parameter int RETIRE_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          opcode,
  input  logic                mem_ack,
  input  logic                alu_zero,
  output logic                mem_req,
  output logic                mem_we,
  output logic                iord,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [2:0]          alu_op,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                illegal,
  output logic                bus_err,
  output logic [RETIRE_W-1:0] retired,
  output logic [3:0]          state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_WB_R   = 4'd3,
    S_EXEC_I = 4'd4,
    S_WB_I   = 4'd5,
    S_ADDR   = 4'd6,
    S_MEM_RD = 4'd7,
    S_WB_MEM = 4'd8,
    S_MEM_WR = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_ADDI = 6'b100000;
  localparam logic [5:0] OP_LW   = 6'b100001;
  localparam logic [5:0] OP_SW   = 6'b100010;
  localparam logic [5:0] OP_ANDI = 6'b100011;
  localparam logic [5:0] OP_ORI  = 6'b100100;
  localparam logic [5:0] OP_BEQ  = 6'b100101;
  localparam logic [5:0] OP_BNE  = 6'b100110;
  localparam logic [5:0] OP_J    = 6'b111111;

  // Wait counter runs 0 .. MEM_TIMEOUT-1; expiry is the last of those cycles.
  localparam bit TIMEOUT_EN  = (MEM_TIMEOUT > 0);
  localparam int WAIT_W      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int WAIT_LAST_I = (MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_LAST_I[WAIT_W-1:0];

  state_t              state_q, state_d;
  logic [5:0]          opcode_q, opcode_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                err_q, err_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;

  // Decode of the latched opcode.
  logic is_r, is_addi, is_lw, is_sw, is_andi, is_ori, is_beq, is_bne, is_j, is_legal;
  assign is_r     = ~opcode_q[5];
  assign is_addi  = (opcode_q == OP_ADDI);
  assign is_lw    = (opcode_q == OP_LW);
  assign is_sw    = (opcode_q == OP_SW);
  assign is_andi  = (opcode_q == OP_ANDI);
  assign is_ori   = (opcode_q == OP_ORI);
  assign is_beq   = (opcode_q == OP_BEQ);
  assign is_bne   = (opcode_q == OP_BNE);
  assign is_j     = (opcode_q == OP_J);
  assign is_legal = is_r | is_addi | is_lw | is_sw | is_andi | is_ori |
                    is_beq | is_bne | is_j;

  // A memory request is live in FETCH (except the bus-error recovery cycle)
  // and in the two data-access states; mem_ack is ignored everywhere else.
  logic mem_active, mem_done, mem_expire;
  assign mem_active = ((state_q == S_FETCH) && !err_q) ||
                      (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign mem_done   = mem_active && mem_ack;
  assign mem_expire = TIMEOUT_EN && mem_active && !mem_ack && (wait_q == WAIT_LAST);

  // Raw Moore/strobe decode, masked by rst_n on the way out.
  logic       dec_mem_req, dec_mem_we, dec_iord, dec_ir_write, dec_pc_write;
  logic [1:0] dec_pc_src, dec_alu_src_b;
  logic       dec_alu_src_a, dec_reg_write, dec_reg_dst, dec_mem_to_reg, dec_illegal;
  logic [2:0] dec_alu_op;

  // State, opcode latch, error pulse, wait counter and retire counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      opcode_q  <= '0;
      wait_q    <= '0;
      err_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      wait_q    <= wait_d;
      err_q     <= err_d;
      retired_q <= retired_d;
    end
  end

  // Next-state, opcode capture, timeout and retire bookkeeping.
  always_comb begin
    logic retire;
    state_d  = state_q;
    opcode_d = opcode_q;
    err_d    = 1'b0;
    retire   = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_done) begin
          opcode_d = opcode;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_r)                           state_d = S_EXEC_R;
        else if (is_addi | is_andi | is_ori) state_d = S_EXEC_I;
        else if (is_lw | is_sw)             state_d = S_ADDR;
        else if (is_beq | is_bne)           state_d = S_BRANCH;
        else if (is_j)                      state_d = S_JUMP;
        else                                state_d = S_FETCH;
      end
      S_EXEC_R: state_d = S_WB_R;
      S_WB_R: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_EXEC_I: state_d = S_WB_I;
      S_WB_I: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_ADDR:   state_d = is_lw ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: if (mem_done) state_d = S_WB_MEM;
      S_WB_MEM: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEM_WR: begin
        if (mem_done) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_BRANCH: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    // Expiry abandons the access; the following FETCH cycle is a recovery
    // cycle with mem_req low and bus_err high.
    if (mem_expire) begin
      state_d = S_FETCH;
      err_d   = 1'b1;
    end

    // Counter restarts whenever the request completes, expires or is idle.
    if (!TIMEOUT_EN || !mem_active || mem_done || mem_expire) wait_d = '0;
    else                                                      wait_d = wait_q + WAIT_W'(1);

    retired_d = retire ? (retired_q + RETIRE_W'(1)) : retired_q;
  end

  // Datapath control decode from the current state.
  always_comb begin
    dec_mem_req    = 1'b0;
    dec_mem_we     = 1'b0;
    dec_iord       = 1'b0;
    dec_ir_write   = 1'b0;
    dec_pc_write   = 1'b0;
    dec_pc_src     = 2'b00;
    dec_alu_src_a  = 1'b0;
    dec_alu_src_b  = 2'b00;
    dec_alu_op     = 3'b000;
    dec_reg_write  = 1'b0;
    dec_reg_dst    = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        dec_mem_req   = ~err_q;
        dec_alu_src_b = 2'b01;
        dec_alu_op    = 3'b001;
        dec_ir_write  = mem_done;
        dec_pc_write  = mem_done;
      end
      S_DECODE: begin
        dec_alu_src_b = 2'b11;
        dec_alu_op    = 3'b001;
        dec_illegal   = ~is_legal;
      end
      S_EXEC_R: begin
        dec_alu_src_a = 1'b1;
        dec_alu_src_b = 2'b00;
        dec_alu_op    = 3'b000;
      end
      S_WB_R: begin
        dec_reg_write = 1'b1;
        dec_reg_dst   = 1'b1;
      end
      S_EXEC_I: begin
        dec_alu_src_a = 1'b1;
        dec_alu_src_b = 2'b10;
        dec_alu_op    = is_addi ? 3'b001 : (is_ori ? 3'b010 : 3'b011);
      end
      S_WB_I: dec_reg_write = 1'b1;
      S_ADDR: begin
        dec_alu_src_a = 1'b1;
        dec_alu_src_b = 2'b10;
        dec_alu_op    = 3'b001;
      end
      S_MEM_RD: begin
        dec_mem_req = 1'b1;
        dec_iord    = 1'b1;
      end
      S_WB_MEM: begin
        dec_reg_write  = 1'b1;
        dec_mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        dec_mem_req = 1'b1;
        dec_mem_we  = 1'b1;
        dec_iord    = 1'b1;
      end
      S_BRANCH: begin
        dec_alu_src_a = 1'b1;
        dec_alu_src_b = 2'b00;
        dec_alu_op    = is_bne ? 3'b111 : 3'b110;
        dec_pc_src    = 2'b01;
        dec_pc_write  = (is_beq & alu_zero) | (is_bne & ~alu_zero);
      end
      S_JUMP: begin
        dec_pc_write = 1'b1;
        dec_pc_src   = 2'b10;
      end
      default: ;
    endcase
  end

  // All outputs forced low while reset is held, so a request drops at once.
  assign mem_req    = rst_n & dec_mem_req;
  assign mem_we     = rst_n & dec_mem_we;
  assign iord       = rst_n & dec_iord;
  assign ir_write   = rst_n & dec_ir_write;
  assign pc_write   = rst_n & dec_pc_write;
  assign pc_src     = rst_n ? dec_pc_src : 2'b00;
  assign alu_src_a  = rst_n & dec_alu_src_a;
  assign alu_src_b  = rst_n ? dec_alu_src_b : 2'b00;
  assign alu_op     = rst_n ? dec_alu_op : 3'b000;
  assign reg_write  = rst_n & dec_reg_write;
  assign reg_dst    = rst_n & dec_reg_dst;
  assign mem_to_reg = rst_n & dec_mem_to_reg;
  assign illegal    = rst_n & dec_illegal;
  assign bus_err    = rst_n & err_q;
  assign retired    = rst_n ? retired_q : '0;
  assign state      = rst_n ? state_q : 4'd0;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: dut_a has no timeout and a 32-bit
// retire counter, dut_b has MEM_TIMEOUT=4 and a 2-bit retire counter.
module tb_multicycle_control_unit;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC_R = 4'd2, S_WB_R = 4'd3,
                         S_EXEC_I = 4'd4, S_WB_I = 4'd5, S_ADDR = 4'd6, S_MEM_RD = 4'd7,
                         S_WB_MEM = 4'd8, S_MEM_WR = 4'd9, S_BRANCH = 4'd10, S_JUMP = 4'd11;

  localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000010, OP_ADDI = 6'b100000,
                         OP_LW = 6'b100001, OP_SW = 6'b100010, OP_ANDI = 6'b100011,
                         OP_ORI = 6'b100100, OP_BEQ = 6'b100101, OP_BNE = 6'b100110,
                         OP_J = 6'b111111, OP_ILL = 6'b101111;

  // Control vector: {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
  //                  alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, illegal, bus_err}
  function automatic logic [17:0] mk(input logic req, input logic we, input logic io,
                                     input logic irw, input logic pcw, input logic [1:0] psrc,
                                     input logic a, input logic [1:0] b, input logic [2:0] op,
                                     input logic rw, input logic rd, input logic m2r,
                                     input logic ill, input logic berr);
    return {req, we, io, irw, pcw, psrc, a, b, op, rw, rd, m2r, ill, berr};
  endfunction

  localparam logic [17:0] F_WAIT = mk(1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b01,3'b001,1'b0,1'b0,1'b0,1'b0,1'b0);
  localparam logic [17:0] F_ACK  = mk(1'b1,1'b0,1'b0,1'b1,1'b1,2'b00,1'b0,2'b01,3'b001,1'b0,1'b0,1'b0,1'b0,1'b0);
  localparam logic [17:0] F_ERR  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b01,3'b001,1'b0,1'b0,1'b0,1'b0,1'b1);
  localparam logic [17:0] C_DEC  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b11,3'b001,1'b0,1'b0,1'b0,1'b0,1'b0);
  localparam logic [17:0] C_DILL = mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b11,3'b001,1'b0,1'b0,1'b0,1'b1,1'b0);
  localparam logic [17:0] C_EXR  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b00,3'b000,1'b0,1'b0,1'b0,1'b0,1'b0);
  localparam logic [17:0] C_WBR  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,3'b000,1'b1,1'b1,1'b0,1'b0,1'b0);
  localparam logic [17:0] C_WBI  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,3'b000,1'b1,1'b0,1'b0,1'b0,1'b0);
  localparam logic [17:0] C_ADDR = mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b10,3'b001,1'b0,1'b0,1'b0,1'b0,1'b0);
  localparam logic [17:0] C_MRD  = mk(1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,3'b000,1'b0,1'b0,1'b0,1'b0,1'b0);
  localparam logic [17:0] C_WBM  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,3'b000,1'b1,1'b0,1'b1,1'b0,1'b0);
  localparam logic [17:0] C_MWR  = mk(1'b1,1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,3'b000,1'b0,1'b0,1'b0,1'b0,1'b0);
  localparam logic [17:0] C_JMP  = mk(1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,2'b00,3'b000,1'b0,1'b0,1'b0,1'b0,1'b0);

  typedef struct packed {
    logic        rst;
    logic        sel;
    logic        ack;
    logic        zero;
    logic [5:0]  op;
    logic [3:0]  st;
    logic [17:0] ctl;
    logic [31:0] ret;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       alu_zero = 1'b0;
  logic       mem_ack_a = 1'b0, mem_ack_b = 1'b0;

  logic mem_req_a, mem_we_a, iord_a, ir_write_a, pc_write_a, alu_src_a_a;
  logic reg_write_a, reg_dst_a, mem_to_reg_a, illegal_a, bus_err_a;
  logic [1:0] pc_src_a, alu_src_b_a;
  logic [2:0] alu_op_a;
  logic [31:0] retired_a;
  logic [3:0] state_a;

  logic mem_req_b, mem_we_b, iord_b, ir_write_b, pc_write_b, alu_src_a_b;
  logic reg_write_b, reg_dst_b, mem_to_reg_b, illegal_b, bus_err_b;
  logic [1:0] pc_src_b, alu_src_b_b;
  logic [2:0] alu_op_b;
  logic [1:0] retired_b;
  logic [3:0] state_b;

  multicycle_control_unit #(.MEM_TIMEOUT(0), .RETIRE_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ack(mem_ack_a), .alu_zero(alu_zero),
    .mem_req(mem_req_a), .mem_we(mem_we_a), .iord(iord_a), .ir_write(ir_write_a),
    .pc_write(pc_write_a), .pc_src(pc_src_a), .alu_src_a(alu_src_a_a), .alu_src_b(alu_src_b_a),
    .alu_op(alu_op_a), .reg_write(reg_write_a), .reg_dst(reg_dst_a), .mem_to_reg(mem_to_reg_a),
    .illegal(illegal_a), .bus_err(bus_err_a), .retired(retired_a), .state(state_a)
  );

  multicycle_control_unit #(.MEM_TIMEOUT(4), .RETIRE_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ack(mem_ack_b), .alu_zero(alu_zero),
    .mem_req(mem_req_b), .mem_we(mem_we_b), .iord(iord_b), .ir_write(ir_write_b),
    .pc_write(pc_write_b), .pc_src(pc_src_b), .alu_src_a(alu_src_a_b), .alu_src_b(alu_src_b_b),
    .alu_op(alu_op_b), .reg_write(reg_write_b), .reg_dst(reg_dst_b), .mem_to_reg(mem_to_reg_b),
    .illegal(illegal_b), .bus_err(bus_err_b), .retired(retired_b), .state(state_b)
  );

  logic [17:0] ctl_a, ctl_b;
  assign ctl_a = {mem_req_a, mem_we_a, iord_a, ir_write_a, pc_write_a, pc_src_a, alu_src_a_a,
                  alu_src_b_a, alu_op_a, reg_write_a, reg_dst_a, mem_to_reg_a, illegal_a, bus_err_a};
  assign ctl_b = {mem_req_b, mem_we_b, iord_b, ir_write_b, pc_write_b, pc_src_b, alu_src_a_b,
                  alu_src_b_b, alu_op_b, reg_write_b, reg_dst_b, mem_to_reg_b, illegal_b, bus_err_b};

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  int unsigned exp_ret_a = 0;
  int unsigned exp_ret_b = 0;
  vec_t        sbq[$];

  // ---------------- scoreboard producers ----------------
  task automatic pv(input logic sel, input logic ack, input logic zero, input logic [5:0] op,
                    input logic [3:0] st, input logic [17:0] ctl);
    vec_t e;
    e.rst = 1'b1; e.sel = sel; e.ack = ack; e.zero = zero; e.op = op;
    e.st = st; e.ctl = ctl;
    e.ret = sel ? (exp_ret_b & 32'd3) : exp_ret_a;
    sbq.push_back(e);
  endtask

  task automatic pr(input logic sel);
    vec_t e;
    exp_ret_a = 0;
    exp_ret_b = 0;
    e.rst = 1'b0; e.sel = sel; e.ack = 1'b0; e.zero = 1'b0; e.op = OP_ADD;
    e.st = S_FETCH; e.ctl = '0; e.ret = '0;
    sbq.push_back(e);
  endtask

  task automatic bump(input logic sel);
    if (sel) exp_ret_b++;
    else     exp_ret_a++;
  endtask

  task automatic push_fetch(input logic sel, input logic [5:0] op, input int nwait);
    $display("txn dut%0d op=%b fetch_wait=%0d", sel, op, nwait);
    for (int i = 0; i < nwait; i++) pv(sel, 1'b0, 1'b0, op, S_FETCH, F_WAIT);
    pv(sel, 1'b1, 1'b0, op, S_FETCH, F_ACK);
  endtask

  // After fetch the opcode input is inverted, so only the latched copy matters.
  task automatic ins_r(input logic sel, input logic [5:0] op);
    push_fetch(sel, op, 0);
    pv(sel, 1'b0, 1'b0, ~op, S_DECODE, C_DEC);
    pv(sel, 1'b0, 1'b0, ~op, S_EXEC_R, C_EXR);
    pv(sel, 1'b0, 1'b0, ~op, S_WB_R, C_WBR);
    bump(sel);
  endtask

  task automatic ins_i(input logic sel, input logic [5:0] op, input logic [2:0] aop);
    push_fetch(sel, op, 0);
    pv(sel, 1'b0, 1'b0, ~op, S_DECODE, C_DEC);
    pv(sel, 1'b0, 1'b0, ~op, S_EXEC_I,
       mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b10,aop,1'b0,1'b0,1'b0,1'b0,1'b0));
    pv(sel, 1'b0, 1'b0, ~op, S_WB_I, C_WBI);
    bump(sel);
  endtask

  task automatic ins_lw(input logic sel, input int dly);
    push_fetch(sel, OP_LW, 0);
    pv(sel, 1'b0, 1'b0, ~OP_LW, S_DECODE, C_DEC);
    pv(sel, 1'b0, 1'b0, ~OP_LW, S_ADDR, C_ADDR);
    for (int i = 0; i < dly; i++) pv(sel, 1'b0, 1'b0, ~OP_LW, S_MEM_RD, C_MRD);
    pv(sel, 1'b1, 1'b0, ~OP_LW, S_MEM_RD, C_MRD);
    pv(sel, 1'b0, 1'b0, ~OP_LW, S_WB_MEM, C_WBM);
    bump(sel);
  endtask

  task automatic ins_sw(input logic sel, input int dly);
    push_fetch(sel, OP_SW, 0);
    pv(sel, 1'b0, 1'b0, ~OP_SW, S_DECODE, C_DEC);
    pv(sel, 1'b0, 1'b0, ~OP_SW, S_ADDR, C_ADDR);
    for (int i = 0; i < dly; i++) pv(sel, 1'b0, 1'b0, ~OP_SW, S_MEM_WR, C_MWR);
    pv(sel, 1'b1, 1'b0, ~OP_SW, S_MEM_WR, C_MWR);
    bump(sel);
  endtask

  task automatic ins_br(input logic sel, input logic [5:0] op, input logic zero, input logic taken);
    logic [2:0] aop;
    aop = (op == OP_BNE) ? 3'b111 : 3'b110;
    push_fetch(sel, op, 0);
    pv(sel, 1'b0, zero, ~op, S_DECODE, C_DEC);
    pv(sel, 1'b0, zero, ~op, S_BRANCH,
       mk(1'b0,1'b0,1'b0,1'b0,taken,2'b01,1'b1,2'b00,aop,1'b0,1'b0,1'b0,1'b0,1'b0));
    bump(sel);
  endtask

  // mem_ack is held high in DECODE/JUMP, where it must have no effect.
  task automatic ins_j(input logic sel);
    push_fetch(sel, OP_J, 0);
    pv(sel, 1'b1, 1'b0, ~OP_J, S_DECODE, C_DEC);
    pv(sel, 1'b1, 1'b0, ~OP_J, S_JUMP, C_JMP);
    bump(sel);
  endtask

  task automatic ins_ill(input logic sel, input logic [5:0] op);
    push_fetch(sel, op, 0);
    pv(sel, 1'b0, 1'b0, ~op, S_DECODE, C_DILL);
  endtask

  // Pops one expectation, drives its inputs after the falling edge and samples.
  task automatic apply(output vec_t e, output logic [53:0] got);
    e = sbq.pop_front();
    @(negedge clk);
    rst_n     = e.rst;
    opcode    = e.op;
    alu_zero  = e.zero;
    mem_ack_a = e.sel ? 1'b0 : e.ack;
    mem_ack_b = e.sel ? e.ack : 1'b0;
    #1;
    got = e.sel ? {state_b, ctl_b, 30'd0, retired_b} : {state_a, ctl_a, retired_a};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    vec_t e; logic [53:0] got; int k = 0;
    pr(1'b0); pr(1'b0);
    pv(1'b0, 1'b0, 1'b0, OP_ADD, S_FETCH, F_WAIT);
    pv(1'b0, 1'b0, 1'b0, OP_ADD, S_FETCH, F_WAIT);
    ins_r(1'b0, OP_ADD);
    pv(1'b0, 1'b0, 1'b0, OP_ADD, S_FETCH, F_WAIT);
    pr(1'b0);
    pv(1'b0, 1'b0, 1'b0, OP_ADD, S_FETCH, F_WAIT);
    while (sbq.size() > 0) begin
      apply(e, got); n_vec++; k++;
      if (got !== {e.st, e.ctl, e.ret}) begin
        n_bad++;
        $display("FAIL reset step %0d: got st=%0d ctl=%b ret=%0d, want st=%0d ctl=%b ret=%0d",
                 k, got[53:50], got[49:32], got[31:0], e.st, e.ctl, e.ret);
      end
    end
  endtask

  task automatic test_alu_ops();
    vec_t e; logic [53:0] got; int k = 0;
    ins_r(1'b0, OP_ADD);
    ins_r(1'b0, OP_SUB);
    ins_i(1'b0, OP_ADDI, 3'b001);
    ins_i(1'b0, OP_ORI, 3'b010);
    ins_i(1'b0, OP_ANDI, 3'b011);
    while (sbq.size() > 0) begin
      apply(e, got); n_vec++; k++;
      if (got !== {e.st, e.ctl, e.ret}) begin
        n_bad++;
        $display("FAIL alu_ops step %0d: got st=%0d ctl=%b ret=%0d, want st=%0d ctl=%b ret=%0d",
                 k, got[53:50], got[49:32], got[31:0], e.st, e.ctl, e.ret);
      end
    end
  endtask

  task automatic test_mem();
    vec_t e; logic [53:0] got; int k = 0;
    ins_lw(1'b0, 3);
    ins_lw(1'b0, 0);
    ins_sw(1'b0, 0);
    push_fetch(1'b0, OP_SW, 2);
    pv(1'b0, 1'b0, 1'b0, ~OP_SW, S_DECODE, C_DEC);
    pv(1'b0, 1'b0, 1'b0, ~OP_SW, S_ADDR, C_ADDR);
    for (int i = 0; i < 6; i++) pv(1'b0, 1'b0, 1'b0, ~OP_SW, S_MEM_WR, C_MWR);
    pv(1'b0, 1'b1, 1'b0, ~OP_SW, S_MEM_WR, C_MWR);
    bump(1'b0);
    pv(1'b0, 1'b0, 1'b0, OP_ADD, S_FETCH, F_WAIT);
    while (sbq.size() > 0) begin
      apply(e, got); n_vec++; k++;
      if (got !== {e.st, e.ctl, e.ret}) begin
        n_bad++;
        $display("FAIL mem step %0d: got st=%0d ctl=%b ret=%0d, want st=%0d ctl=%b ret=%0d",
                 k, got[53:50], got[49:32], got[31:0], e.st, e.ctl, e.ret);
      end
    end
  endtask

  task automatic test_branch_jump_illegal();
    vec_t e; logic [53:0] got; int k = 0;
    ins_br(1'b0, OP_BEQ, 1'b1, 1'b1);
    ins_br(1'b0, OP_BNE, 1'b1, 1'b0);
    ins_br(1'b0, OP_BEQ, 1'b0, 1'b0);
    ins_br(1'b0, OP_BNE, 1'b0, 1'b1);
    ins_ill(1'b0, OP_ILL);
    ins_ill(1'b0, 6'b110000);
    ins_j(1'b0);
    pv(1'b0, 1'b0, 1'b0, OP_ADD, S_FETCH, F_WAIT);
    while (sbq.size() > 0) begin
      apply(e, got); n_vec++; k++;
      if (got !== {e.st, e.ctl, e.ret}) begin
        n_bad++;
        $display("FAIL branch_jump_illegal step %0d: got st=%0d ctl=%b ret=%0d, want st=%0d ctl=%b ret=%0d",
                 k, got[53:50], got[49:32], got[31:0], e.st, e.ctl, e.ret);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t e; logic [53:0] got; int k = 0;
    ins_r(1'b0, OP_ADD);
    ins_lw(1'b0, 1);
    ins_sw(1'b0, 0);
    ins_j(1'b0);
    ins_i(1'b0, OP_ANDI, 3'b011);
    ins_br(1'b0, OP_BNE, 1'b0, 1'b1);
    pv(1'b0, 1'b0, 1'b0, OP_ADD, S_FETCH, F_WAIT);
    while (sbq.size() > 0) begin
      apply(e, got); n_vec++; k++;
      if (got !== {e.st, e.ctl, e.ret}) begin
        n_bad++;
        $display("FAIL back_to_back step %0d: got st=%0d ctl=%b ret=%0d, want st=%0d ctl=%b ret=%0d",
                 k, got[53:50], got[49:32], got[31:0], e.st, e.ctl, e.ret);
      end
    end
  endtask

  task automatic test_timeout();
    vec_t e; logic [53:0] got; int k = 0;
    pr(1'b1); pr(1'b1);
    // FETCH with no ack: four request cycles, then a recovery cycle (ack ignored).
    for (int i = 0; i < 4; i++) pv(1'b1, 1'b0, 1'b0, OP_ADD, S_FETCH, F_WAIT);
    pv(1'b1, 1'b1, 1'b0, OP_ADD, S_FETCH, F_ERR);
    // sw with no data ack: bus error, no retire.
    push_fetch(1'b1, OP_SW, 0);
    pv(1'b1, 1'b0, 1'b0, ~OP_SW, S_DECODE, C_DEC);
    pv(1'b1, 1'b0, 1'b0, ~OP_SW, S_ADDR, C_ADDR);
    for (int i = 0; i < 4; i++) pv(1'b1, 1'b0, 1'b0, ~OP_SW, S_MEM_WR, C_MWR);
    pv(1'b1, 1'b0, 1'b0, OP_ADD, S_FETCH, F_ERR);
    // Ack on the expiry cycle completes normally.
    ins_sw(1'b1, 3);
    ins_lw(1'b1, 3);
    push_fetch(1'b1, OP_J, 3);
    pv(1'b1, 1'b0, 1'b0, ~OP_J, S_DECODE, C_DEC);
    pv(1'b1, 1'b0, 1'b0, ~OP_J, S_JUMP, C_JMP);
    bump(1'b1);
    pv(1'b1, 1'b0, 1'b0, OP_ADD, S_FETCH, F_WAIT);
    while (sbq.size() > 0) begin
      apply(e, got); n_vec++; k++;
      if (got !== {e.st, e.ctl, e.ret}) begin
        n_bad++;
        $display("FAIL timeout step %0d: got st=%0d ctl=%b ret=%0d, want st=%0d ctl=%b ret=%0d",
                 k, got[53:50], got[49:32], got[31:0], e.st, e.ctl, e.ret);
      end
    end
  endtask

  task automatic test_retire_wrap();
    vec_t e; logic [53:0] got; int k = 0;
    pr(1'b1);
    ins_j(1'b1);
    ins_br(1'b1, OP_BEQ, 1'b1, 1'b1);
    ins_ill(1'b1, OP_ILL);
    ins_r(1'b1, OP_ADD);
    ins_i(1'b1, OP_ADDI, 3'b001);
    ins_sw(1'b1, 0);
    pv(1'b1, 1'b0, 1'b0, OP_ADD, S_FETCH, F_WAIT);
    while (sbq.size() > 0) begin
      apply(e, got); n_vec++; k++;
      if (got !== {e.st, e.ctl, e.ret}) begin
        n_bad++;
        $display("FAIL retire_wrap step %0d: got st=%0d ctl=%b ret=%0d, want st=%0d ctl=%b ret=%0d",
                 k, got[53:50], got[49:32], got[31:0], e.st, e.ctl, e.ret);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_mem();
    test_branch_jump_illegal();
    test_back_to_back();
    test_timeout();
    test_retire_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
